ext_mem_ctlr: RTL and testbench
===============================

Name: ext_mem_ctlr

Overview:
- Sits directly downstream of the CPU block's external memory port; consumes its addr/data/read_q/write_q and returns data, read_dn and write_dn.
- Converts the level request / level done (four-phase) handshake into timed cycles for a synchronous SRAM-style device with a fixed number of wait states.
- Implements the MEM_CTLR_* state set: WAIT, READ_SET_ADDRESS, READ_DATA_GET, READ_FINISH, WRITE_SET_ADDRESS, WRITE_SET_WE, WRITE_FINISH.

Parameters:
- ADDR_W, 32, address width; matches `ADDR_SIZE.
- DATA_W, 32, data width; matches `DATA_SIZE.
- WAIT_STATES, 2, extra memory cycles per access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr_in  in  ADDR_W  request address from the CPU block (its addr_out).
- data_in  in  DATA_W  write data from the CPU block (its data_out).
- read_q  in  1  read request level from the CPU block.
- write_q  in  1  write request level from the CPU block.
- rw_halt_in  in  1  halt from the CPU block; blocks acceptance of new requests.
- addr_out  out  ADDR_W  echoed read address to the CPU block's addr_in.
- data_out  out  DATA_W  read data to the CPU block's data_in.
- read_dn  out  1  read done level.
- write_dn  out  1  write done level.
- rw_halt_out  out  1  controller busy, to the CPU block's rw_halt_in.
- mem_addr  out  ADDR_W  device address.
- mem_wdata  out  DATA_W  device write data.
- mem_rdata  in  DATA_W  device read data; sampled synchronously.
- mem_cs  out  1  device chip select.
- mem_oe  out  1  device output enable.
- mem_we  out  1  device write enable.

Behaviour:
- Reset (async, rst=1): state=WAIT, counter=0, and every output is 0.
- All outputs are registered. addr_out and data_out must be 0 outside READ_FINISH, because upstream buses are OR-combined.
- WAIT:
  - rw_halt_in=1: no request is accepted. Requests stay pending.
  - Else read_q=1: latch addr_in, go to READ_SET_ADDRESS. read_q has priority when read_q and write_q are both 1; the write is served after the read handshake completes, if write_q is still held.
  - Else write_q=1: latch addr_in and data_in, go to WRITE_SET_ADDRESS.
- READ_SET_ADDRESS (1 cycle): mem_addr=latched address, mem_cs=1, mem_oe=1. Load counter=WAIT_STATES, go to READ_DATA_GET.
- READ_DATA_GET:
  - Hold mem_cs and mem_oe.
  - counter!=0: decrement the counter.
  - counter==0: capture mem_rdata into data_out, set addr_out=latched address, read_dn=1, drop mem_cs/mem_oe, go to READ_FINISH.
- READ_FINISH: hold read_dn, data_out and addr_out while read_q=1. When read_q=0, clear all three to 0 and go to WAIT.
- WRITE_SET_ADDRESS (1 cycle): mem_addr and mem_wdata driven, mem_cs=1, mem_we=0. Load counter=WAIT_STATES, go to WRITE_SET_WE.
- WRITE_SET_WE:
  - mem_we=1 for exactly WAIT_STATES+1 cycles, then mem_we=0 and write_dn=1, go to WRITE_FINISH.
  - mem_cs, mem_addr and mem_wdata are held through the first WRITE_FINISH cycle (hold time), then cleared.
- WRITE_FINISH: hold write_dn while write_q=1. When write_q=0, clear write_dn and go to WAIT.
- Latency: request sampled at edge k gives done high after edge k+WAIT_STATES+2 (read and write alike).
- Minimum back-to-back period: WAIT_STATES+4 cycles, including the request-drop cycle and one WAIT cycle.
- rw_halt_out = 1 in every state except WAIT. It rises the cycle after acceptance.
- Abort (request drops before done):
  - The device cycle always completes; mid-transaction request changes are ignored.
  - On reaching FINISH with the request already 0: done is not asserted and data_out stays 0. Next state is WAIT.
- rw_halt_in asserted mid-transaction: ignored. It only gates acceptance in WAIT.
- Reset mid-transaction: immediate return to WAIT with all outputs 0; no done is generated.
- Counter is 4 bits wide. WAIT_STATES=0 is legal: 1-cycle READ_DATA_GET, 1-cycle mem_we.

Test Plan:
- WAIT_STATES=2; read_q=1 at edge 0, addr=0x100, mem_rdata=0xDEADBEEF → read_dn high after edge 4 with data_out=0xDEADBEEF and addr_out=0x100. read_q dropped → all three 0 one cycle later.
- Write to addr 0x20, data 0x55AA → mem_we high exactly 3 cycles with mem_addr=0x20 and mem_wdata=0x55AA held one cycle past mem_we fall. write_dn high after edge 4.
- read_q and write_q both 1 → read completes first; write_q still held → WRITE_SET_ADDRESS entered within 2 cycles of read_q drop. Exactly one mem_we pulse.
- rw_halt_in=1 with read_q=1 for 10 cycles → mem_cs stays 0 and rw_halt_out stays 0. rw_halt_in drops → read proceeds with normal latency.
- read_q dropped during READ_DATA_GET → full mem_oe cycle occurs, read_dn never asserts, data_out stays 0, controller returns to WAIT.
- rst pulsed during WRITE_SET_WE → mem_we, mem_cs and write_dn are 0 immediately (async). A new request after reset completes normally.

Source files
------------

// File: rtl/ext_mem_ctlr.sv
// ext_mem_ctlr: four-phase CPU request to timed synchronous SRAM cycles with fixed wait states
module ext_mem_ctlr #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  input  logic              rw_halt_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic              rw_halt_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we
);
  typedef enum logic [2:0] {
    MEM_CTLR_WAIT,
    MEM_CTLR_READ_SET_ADDRESS,
    MEM_CTLR_READ_DATA_GET,
    MEM_CTLR_READ_FINISH,
    MEM_CTLR_WRITE_SET_ADDRESS,
    MEM_CTLR_WRITE_SET_WE,
    MEM_CTLR_WRITE_FINISH
  } state_t;
  state_t     state;
  logic [3:0] counter;
  // mem_addr/mem_wdata double as the request latches; addr_out/data_out stay 0 except in READ_FINISH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MEM_CTLR_WAIT;
      counter     <= '0;
      addr_out    <= '0;
      data_out    <= '0;
      read_dn     <= 1'b0;
      write_dn    <= 1'b0;
      rw_halt_out <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_cs      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      case (state)
        MEM_CTLR_WAIT: begin
          if (!rw_halt_in && read_q) begin
            mem_addr    <= addr_in;
            mem_cs      <= 1'b1;
            mem_oe      <= 1'b1;
            rw_halt_out <= 1'b1;
            state       <= MEM_CTLR_READ_SET_ADDRESS;
          end else if (!rw_halt_in && write_q) begin
            mem_addr    <= addr_in;
            mem_wdata   <= data_in;
            mem_cs      <= 1'b1;
            rw_halt_out <= 1'b1;
            state       <= MEM_CTLR_WRITE_SET_ADDRESS;
          end
        end
        MEM_CTLR_READ_SET_ADDRESS: begin
          counter <= 4'(WAIT_STATES);
          state   <= MEM_CTLR_READ_DATA_GET;
        end
        MEM_CTLR_READ_DATA_GET: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_addr <= '0;
            if (read_q) begin
              data_out <= mem_rdata;
              addr_out <= mem_addr;
              read_dn  <= 1'b1;
            end
            state <= MEM_CTLR_READ_FINISH;
          end
        end
        MEM_CTLR_READ_FINISH: begin
          if (!read_q) begin
            read_dn     <= 1'b0;
            data_out    <= '0;
            addr_out    <= '0;
            rw_halt_out <= 1'b0;
            state       <= MEM_CTLR_WAIT;
          end
        end
        MEM_CTLR_WRITE_SET_ADDRESS: begin
          counter <= 4'(WAIT_STATES);
          mem_we  <= 1'b1;
          state   <= MEM_CTLR_WRITE_SET_WE;
        end
        MEM_CTLR_WRITE_SET_WE: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            mem_we   <= 1'b0;
            write_dn <= write_q;
            state    <= MEM_CTLR_WRITE_FINISH;
          end
        end
        MEM_CTLR_WRITE_FINISH: begin
          mem_cs    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (!write_q) begin
            write_dn    <= 1'b0;
            rw_halt_out <= 1'b0;
            state       <= MEM_CTLR_WAIT;
          end
        end
        default: state <= MEM_CTLR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_ctlr.sv
// tb_ext_mem_ctlr: directed vectors for ext_mem_ctlr with WAIT_STATES=2
module tb_ext_mem_ctlr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_in = '0, data_in = '0, mem_rdata = '0;
  logic        read_q = 1'b0, write_q = 1'b0, rw_halt_in = 1'b0;
  logic [31:0] addr_out, data_out, mem_addr, mem_wdata;
  logic        read_dn, write_dn, rw_halt_out, mem_cs, mem_oe, mem_we;
  int vectors = 0, miscompares = 0;
  ext_mem_ctlr #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .read_q(read_q), .write_q(write_q), .rw_halt_in(rw_halt_in),
    .addr_out(addr_out), .data_out(data_out), .read_dn(read_dn), .write_dn(write_dn),
    .rw_halt_out(rw_halt_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cnt, bad;
    step();
    step();
    check("reset outputs", {addr_out, data_out, read_dn, write_dn, rw_halt_out, mem_cs, mem_oe, mem_we}, '0);
    check("reset mem bus", {mem_addr, mem_wdata}, '0);
    rst = 1'b0;
    step();
    // plain read: accepted at edge 0, done after edge 4
    read_q = 1'b1; addr_in = 32'h100; mem_rdata = 32'hDEADBEEF;
    step();
    check("rd e0 cs/oe/halt", {mem_cs, mem_oe, mem_we, rw_halt_out}, 4'b1101);
    check("rd e0 mem_addr", mem_addr, 32'h100);
    check("rd e0 addr_out", addr_out, 0);
    step(); step(); step();
    check("rd e3 read_dn", read_dn, 0);
    check("rd e3 data_out", data_out, 0);
    step();
    check("rd e4 read_dn", read_dn, 1);
    check("rd e4 data_out", data_out, 32'hDEADBEEF);
    check("rd e4 addr_out", addr_out, 32'h100);
    check("rd e4 cs/oe", {mem_cs, mem_oe}, 2'b00);
    read_q = 1'b0;
    step();
    check("rd drop outs", {read_dn, data_out, addr_out, rw_halt_out}, '0);
    step();
    // plain write
    write_q = 1'b1; addr_in = 32'h20; data_in = 32'h55AA;
    step();
    check("wr e0 cs/we/halt", {mem_cs, mem_we, rw_halt_out}, 3'b101);
    check("wr e0 bus", {mem_addr, mem_wdata}, {32'h20, 32'h55AA});
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      cnt += int'(mem_we);
    end
    check("wr we cycles", cnt, 3);
    check("wr e3 write_dn", write_dn, 0);
    step();
    check("wr e4 we/dn", {mem_we, write_dn}, 2'b01);
    check("wr e4 hold bus", {mem_cs, mem_addr, mem_wdata}, {1'b1, 32'h20, 32'h55AA});
    step();
    check("wr e5 bus cleared", {mem_cs, mem_addr, mem_wdata}, '0);
    check("wr e5 write_dn held", write_dn, 1);
    write_q = 1'b0;
    step();
    check("wr drop", {write_dn, rw_halt_out}, 2'b00);
    step();
    // read and write together: read first, then write
    read_q = 1'b1; write_q = 1'b1; addr_in = 32'h300; data_in = 32'hA5; mem_rdata = 32'h11;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(mem_we);
    end
    check("rw read_dn", {read_dn, write_dn}, 2'b10);
    check("rw data_out", data_out, 32'h11);
    read_q = 1'b0;
    step();
    check("rw read released", read_dn, 0);
    step();
    check("rw write started", {mem_cs, mem_oe, mem_we}, 3'b100);
    check("rw write addr", mem_wdata, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(mem_we);
    end
    check("rw we cycles", cnt, 3);
    check("rw write_dn", write_dn, 1);
    write_q = 1'b0;
    step(); step();
    // halt blocks acceptance
    rw_halt_in = 1'b1; read_q = 1'b1; addr_in = 32'h44; mem_rdata = 32'h12345678;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      bad += int'(mem_cs | rw_halt_out);
    end
    check("halt blocks", bad, 0);
    rw_halt_in = 1'b0;
    step();
    check("halt release accept", {mem_cs, rw_halt_out}, 2'b11);
    rw_halt_in = 1'b1;
    step(); step(); step();
    check("halt mid-txn e3", read_dn, 0);
    step();
    check("halt read_dn", read_dn, 1);
    check("halt data", {addr_out, data_out}, {32'h44, 32'h12345678});
    rw_halt_in = 1'b0; read_q = 1'b0;
    step(); step();
    // aborted read
    read_q = 1'b1; addr_in = 32'h80; mem_rdata = 32'hCAFE;
    step();
    cnt = int'(mem_oe);
    step();
    read_q = 1'b0;
    cnt += int'(mem_oe);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(mem_oe);
      bad += int'(read_dn | (data_out != 0) | (addr_out != 0));
    end
    check("abort oe cycles", cnt, 4);
    check("abort no done", bad, 0);
    check("abort back to wait", rw_halt_out, 0);
    // reset during WRITE_SET_WE
    write_q = 1'b1; addr_in = 32'h30; data_in = 32'h77;
    step(); step(); step();
    check("pre-rst we", mem_we, 1);
    rst = 1'b1;
    #1;
    check("async rst", {mem_we, mem_cs, write_dn, rw_halt_out, mem_addr}, '0);
    #2;
    rst = 1'b0;
    write_q = 1'b0;
    step();
    write_q = 1'b1; addr_in = 32'h40; data_in = 32'h99;
    step();
    check("post-rst accept", {mem_cs, mem_addr, mem_wdata}, {1'b1, 32'h40, 32'h99});
    step(); step(); step();
    check("post-rst e3", write_dn, 0);
    step();
    check("post-rst write_dn", write_dn, 1);
    write_q = 1'b0;
    step();
    check("post-rst drop", {write_dn, rw_halt_out}, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
